// File: rtl/instr_fetch.sv
// Single-stage instruction fetch: a PC register feeds a combinational instruction memory,
// and a valid/ready output stage holds the fetched word. Redirects flush that stage.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_r;
  logic        out_valid_r;
  logic [31:0] out_pc_r;
  logic [31:0] out_instr_r;
  logic        misalign_r;
  logic [31:0] fetch_count_r;

  logic [31:0] pc_s;
  logic        out_valid_s;
  logic [31:0] out_pc_s;
  logic [31:0] out_instr_s;
  logic        misalign_s;
  logic [31:0] fetch_count_s;

  logic        slot_open_s;
  logic        fire_s;
  logic        handshake_s;

  // Handshake and fetch qualifiers derived from the current output stage.
  always_comb begin
    slot_open_s = !out_valid_r || out_ready;
    handshake_s = out_valid_r && out_ready;
    fire_s      = slot_open_s && !halt && !redirect_valid;
  end

  // Next-state selection: redirect beats fetch, which beats bubble/hold.
  always_comb begin
    pc_s          = pc_r;
    out_valid_s   = out_valid_r;
    out_pc_s      = out_pc_r;
    out_instr_s   = out_instr_r;
    misalign_s    = 1'b0;
    fetch_count_s = fetch_count_r;

    // A word flushed by a concurrent redirect was still consumed, so it counts.
    if (handshake_s) begin
      fetch_count_s = fetch_count_r + 32'd1;
    end else begin
      fetch_count_s = fetch_count_r;
    end

    if (redirect_valid) begin
      pc_s        = {redirect_pc[31:2], 2'b00};
      out_valid_s = 1'b0;
      out_instr_s = NOP_INSTR;
      misalign_s  = (redirect_pc[1:0] != 2'b00);
    end else if (fire_s) begin
      pc_s        = pc_r + 32'd4;
      out_valid_s = 1'b1;
      out_pc_s    = pc_r;
      out_instr_s = imem_instr;
    end else if (slot_open_s) begin
      out_valid_s = 1'b0;
      out_instr_s = NOP_INSTR;
    end else begin
      pc_s        = pc_r;
      out_valid_s = out_valid_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      out_valid_r   <= 1'b0;
      out_pc_r      <= 32'h0000_0000;
      out_instr_r   <= NOP_INSTR;
      misalign_r    <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      pc_r          <= pc_s;
      out_valid_r   <= out_valid_s;
      out_pc_r      <= out_pc_s;
      out_instr_r   <= out_instr_s;
      misalign_r    <= misalign_s;
      fetch_count_r <= fetch_count_s;
    end
  end

  assign imem_addr   = pc_r;
  assign out_valid   = out_valid_r;
  assign out_pc      = out_pc_r;
  assign out_instr   = out_instr_r;
  assign misalign    = misalign_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed plus randomized bench for instr_fetch, checked against a cycle-level
// behavioural model of the fetch rules.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign;
  logic [31:0] fetch_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: next PC, the word held for the consumer, handshake count.
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_opc;
  logic [31:0] m_instr;
  logic        m_mis;
  logic [31:0] m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0050_0513;
      32'h0000_0004: mem_word = 32'h00a0_0593;
      32'h0000_0008: mem_word = 32'h0140_0613;
      default:       mem_word = (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endcase
  endfunction

  assign imem_instr = mem_word(imem_addr);

  instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .misalign(misalign), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the rules for one clock edge to the reference state.
  task automatic model_edge();
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_opc = 32'h0; m_instr = NOP; m_mis = 1'b0; m_cnt = 32'h0;
    end else begin
      if (m_valid && out_ready) m_cnt = m_cnt + 32'd1;
      m_mis = redirect_valid && (redirect_pc % 32'd4 != 32'd0);
      if (redirect_valid) begin
        m_pc = redirect_pc - (redirect_pc % 32'd4);
        m_valid = 1'b0; m_instr = NOP;
      end else if (!m_valid || out_ready) begin
        if (!halt) begin
          m_opc = m_pc; m_instr = mem_word(m_pc); m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end else begin
          m_valid = 1'b0; m_instr = NOP;
        end
      end
    end
  endtask

  // One clock: model and DUT advance together, then every output is compared.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("imem_addr",   imem_addr,          m_pc);
    check("out_valid",   {31'd0, out_valid}, {31'd0, m_valid});
    check("out_pc",      out_pc,             m_opc);
    check("out_instr",   out_instr,          m_instr);
    check("misalign",    {31'd0, misalign},  {31'd0, m_mis});
    check("fetch_count", fetch_count,        m_cnt);
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0; out_ready = 1'b1;
    m_pc = 32'h0; m_valid = 1'b0; m_opc = 32'h0; m_instr = NOP; m_mis = 1'b0; m_cnt = 32'h0;
    @(posedge clk); #1;
    step(); step();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, NOP);
    check("rst_count", fetch_count, 32'd0);

    // Straight-line fetch of three words.
    rst = 1'b0;
    step(); check("seq_pc0", out_pc, 32'h0); check("seq_w0", out_instr, 32'h0050_0513);
    step(); check("seq_pc4", out_pc, 32'h4); check("seq_w1", out_instr, 32'h00a0_0593);
    step(); check("seq_pc8", out_pc, 32'h8); check("seq_w2", out_instr, 32'h0140_0613);
    step(); check("seq_cnt3", fetch_count, 32'd3);

    // Backpressure on word1.
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_pc", out_pc, 32'h4);
      check("bp_instr", out_instr, 32'h00a0_0593);
      check("bp_addr", imem_addr, 32'h8);
      check("bp_cnt", fetch_count, 32'd1);
    end

    // Redirect while stalled, then aligned target fetch.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step(); check("rd_valid", {31'd0, out_valid}, 32'd0); check("rd_nop", out_instr, NOP);
    redirect_valid = 1'b0; out_ready = 1'b1;
    step(); check("rd_pc", out_pc, 32'h40); check("rd_v1", {31'd0, out_valid}, 32'd1);

    // Misaligned redirect.
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step(); check("mis_hi", {31'd0, misalign}, 32'd1);
    redirect_valid = 1'b0;
    step(); check("mis_lo", {31'd0, misalign}, 32'd0); check("mis_pc", out_pc, 32'h40);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    step(); check("wrap_top", out_pc, 32'hFFFF_FFFC);
    step(); check("wrap_zero", out_pc, 32'h0);

    // Halt for two cycles after fetching address 4.
    rst = 1'b1; step();
    rst = 1'b0; step(); step();
    halt = 1'b1;
    step(); check("halt_v0", {31'd0, out_valid}, 32'd0);
    step(); check("halt_v1", {31'd0, out_valid}, 32'd0);
    halt = 1'b0;
    step(); check("halt_resume", out_pc, 32'h8);

    // Reset dominates concurrent redirect and halt.
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h123; halt = 1'b1; out_ready = 1'b0;
    step();
    check("rst2_addr", imem_addr, 32'h0); check("rst2_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_pc", out_pc, 32'h0); check("rst2_cnt", fetch_count, 32'd0);
    check("rst2_mis", {31'd0, misalign}, 32'd0);

    // Randomized traffic.
    rst = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 49) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      halt           = ($urandom_range(0, 3) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
